// File: rtl/dual_issue_decode_queue.sv
// Fetch buffer with registered dual-issue MIPS32 decode; optional counters under DECODE_PERF_CNT_EN.
// Latency: a push at edge t reaches out_valid after edge t+1 (no bypass); flush clears everything in one edge.
// Backpressure: in_ready drops below two free entries; the output register holds while out_valid & !out_ready.
module dual_issue_decode_queue #(
    parameter int DEPTH  = 8,
    parameter int ISSUE  = 2,
    parameter int CTRL_W = 17
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [1:0]                in_cnt,
    input  logic [63:0]               in_instr,
    input  logic [63:0]               in_pc,
    output logic                      in_ready,
    output logic [ISSUE-1:0]          out_valid,
    input  logic                      out_ready,
    output logic [32*ISSUE-1:0]       out_instr,
    output logic [32*ISSUE-1:0]       out_pc,
    output logic [CTRL_W*ISSUE-1:0]   out_ctrl,
    output logic [$clog2(DEPTH):0]    q_count
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]               perf_single,
    output logic [31:0]               perf_dual
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam int C_REGWRITE = 16;
    localparam int C_REGDST   = 15;
    localparam int C_ALUSRC   = 14;
    localparam int C_BRANCH   = 13;
    localparam int C_MEMTOREG = 12;
    localparam int C_JUMP     = 11;
    localparam int C_JAL      = 10;
    localparam int C_JR       = 9;
    localparam int C_BAL      = 8;
    localparam int C_MEMEN    = 7;
    localparam int C_HILO     = 6;
    localparam int C_BRK      = 5;
    localparam int C_SYSCALL  = 4;
    localparam int C_RESERVE  = 3;
    localparam int C_ERET     = 2;
    localparam int C_CP0WE    = 1;
    localparam int C_CP0SEL   = 0;

    function automatic logic [CTRL_W-1:0] decode(input logic [31:0] ins);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h08: c[C_JR] = 1'b1;
                    6'h09: begin c[C_REGWRITE] = 1'b1; c[C_REGDST] = 1'b1; c[C_JR] = 1'b1; end
                    6'h0C: c[C_SYSCALL] = 1'b1;
                    6'h0D: c[C_BRK] = 1'b1;
                    6'h10, 6'h12: begin
                        c[C_REGWRITE] = 1'b1; c[C_REGDST] = 1'b1; c[C_HILO] = 1'b1;
                    end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: c[C_HILO] = 1'b1;
                    default: begin c[C_REGWRITE] = 1'b1; c[C_REGDST] = 1'b1; end
                endcase
            end
            6'h01: begin
                case (ins[20:16])
                    5'h00, 5'h01: c[C_BRANCH] = 1'b1;
                    5'h10, 5'h11: begin
                        c[C_REGWRITE] = 1'b1; c[C_BRANCH] = 1'b1; c[C_BAL] = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            6'h02: c[C_JUMP] = 1'b1;
            6'h03: begin c[C_REGWRITE] = 1'b1; c[C_JUMP] = 1'b1; c[C_JAL] = 1'b1; end
            6'h04, 6'h05, 6'h06, 6'h07: c[C_BRANCH] = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                c[C_REGWRITE] = 1'b1; c[C_ALUSRC] = 1'b1;
            end
            6'h10: begin
                if (ins == 32'h4200_0018)
                    c[C_ERET] = 1'b1;
                else if (ins[25:21] == 5'h00 && ins[10:3] == 8'h00) begin
                    c[C_REGWRITE] = 1'b1; c[C_CP0SEL] = 1'b1;
                end else if (ins[25:21] == 5'h04 && ins[10:3] == 8'h00)
                    c[C_CP0WE] = 1'b1;
                else
                    c[C_RESERVE] = 1'b1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                c[C_REGWRITE] = 1'b1; c[C_ALUSRC] = 1'b1; c[C_MEMTOREG] = 1'b1; c[C_MEMEN] = 1'b1;
            end
            6'h28, 6'h29, 6'h2B: begin c[C_ALUSRC] = 1'b1; c[C_MEMEN] = 1'b1; end
            default: c[C_RESERVE] = 1'b1;
        endcase
        return c;
    endfunction

    logic [63:0]       mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, wr_ptr_q, rd_nxt, wr_nxt;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        ov_q, ov_d;
    logic [63:0]       oi_q, oi_d, op_q, op_d;
    logic [2*CTRL_W-1:0] oc_q, oc_d;

    logic [63:0]       head0, head1;
    logic [CTRL_W-1:0] ctrl0, ctrl1;
    logic [4:0]        dest0;
    logic              blk0, blk1, rd_rt1, raw, pair, load;
    logic [1:0]        push_n, pop_n;

    assign rd_nxt = rd_ptr_q + AW'(1);
    assign wr_nxt = wr_ptr_q + AW'(1);
    assign head0  = mem_q[rd_ptr_q];
    assign head1  = mem_q[rd_nxt];
    assign ctrl0  = decode(head0[31:0]);
    assign ctrl1  = decode(head1[31:0]);

    assign in_ready = (cnt_q <= CW'(DEPTH - 2));
    assign push_n   = (in_valid && in_ready) ? ((in_cnt == 2'd2) ? 2'd2 : (in_cnt == 2'd1) ? 2'd1 : 2'd0)
                                             : 2'd0;

    // Slot1 may not follow anything that redirects or serialises, nor be a serialising instr itself.
    assign blk0 = ctrl0[C_BRANCH] | ctrl0[C_JUMP] | ctrl0[C_JAL] | ctrl0[C_JR] | ctrl0[C_BAL] |
                  ctrl0[C_HILO] | ctrl0[C_BRK] | ctrl0[C_SYSCALL] | ctrl0[C_RESERVE] |
                  ctrl0[C_ERET] | ctrl0[C_CP0WE] | ctrl0[C_CP0SEL];
    assign blk1 = ctrl1[C_BRK] | ctrl1[C_SYSCALL] | ctrl1[C_RESERVE] |
                  ctrl1[C_ERET] | ctrl1[C_CP0WE] | ctrl1[C_CP0SEL];

    assign dest0  = ctrl0[C_REGDST] ? head0[15:11] :
                    (ctrl0[C_JAL] | ctrl0[C_BAL]) ? 5'd31 : head0[20:16];
    assign rd_rt1 = ctrl1[C_REGDST] | (ctrl1[C_MEMEN] & ~ctrl1[C_MEMTOREG]) | ctrl1[C_CP0WE] |
                    (head1[31:26] == 6'h04) | (head1[31:26] == 6'h05);
    assign raw    = ctrl0[C_REGWRITE] && (dest0 != 5'd0) &&
                    ((dest0 == head1[25:21]) || (rd_rt1 && (dest0 == head1[20:16])));

    assign pair  = (ISSUE == 2) && (cnt_q >= CW'(2)) && !blk0 && !blk1 && !raw;
    assign load  = (!ov_q[0] || out_ready) && (cnt_q != '0);
    assign pop_n = load ? (pair ? 2'd2 : 2'd1) : 2'd0;

    always_comb begin
        ov_d = ov_q;
        oi_d = oi_q;
        op_d = op_q;
        oc_d = oc_q;
        if (load) begin
            ov_d = {pair, 1'b1};
            oi_d = {pair ? head1[31:0]  : 32'h0, head0[31:0]};
            op_d = {pair ? head1[63:32] : 32'h0, head0[63:32]};
            oc_d = {pair ? ctrl1 : {CTRL_W{1'b0}}, ctrl0};
        end else if (ov_q[0] && out_ready) begin
            ov_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ov_q     <= '0;
            oi_q     <= '0;
            op_q     <= '0;
            oc_q     <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ov_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + AW'(pop_n);
            wr_ptr_q <= wr_ptr_q + AW'(push_n);
            cnt_q    <= cnt_q + CW'(push_n) - CW'(pop_n);
            ov_q     <= ov_d;
            oi_q     <= oi_d;
            op_q     <= op_d;
            oc_q     <= oc_d;
        end
    end

    // Storage carries no reset; occupancy alone defines what is live.
    always_ff @(posedge clk) begin
        if (!flush && push_n != 2'd0)
            mem_q[wr_ptr_q] <= {in_pc[31:0], in_instr[31:0]};
        if (!flush && push_n == 2'd2)
            mem_q[wr_nxt] <= {in_pc[63:32], in_instr[63:32]};
    end

    assign out_valid = ov_q[ISSUE-1:0];
    assign out_instr = oi_q[32*ISSUE-1:0];
    assign out_pc    = op_q[32*ISSUE-1:0];
    assign out_ctrl  = oc_q[CTRL_W*ISSUE-1:0];
    assign q_count   = cnt_q;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_single_q, perf_dual_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_single_q <= '0;
            perf_dual_q   <= '0;
        end else if (ov_q[0] && out_ready) begin
            if (!ov_q[1]) begin
                if (perf_single_q != 32'hFFFF_FFFF) perf_single_q <= perf_single_q + 32'd1;
            end else begin
                if (perf_dual_q != 32'hFFFF_FFFF) perf_dual_q <= perf_dual_q + 32'd1;
            end
        end
    end

    assign perf_single = perf_single_q;
    assign perf_dual   = perf_dual_q;
`endif

endmodule

// File: tb/tb_dual_issue_decode_queue.sv
// Directed-vector bench for dual_issue_decode_queue (DEPTH=8, ISSUE=2).
module tb_dual_issue_decode_queue;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, out_ready;
    logic [1:0]  in_cnt;
    logic [63:0] in_instr, in_pc;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_instr, out_pc;
    logic [33:0] out_ctrl;
    logic [3:0]  q_count;

    int nvec = 0;
    int nerr = 0;

    localparam logic [31:0] ADDU   = 32'h0022_1821;
    localparam logic [31:0] ORI    = 32'h34A4_0001;
    localparam logic [31:0] ADDIU  = 32'h2402_0005;
    localparam logic [31:0] ADDU_R = 32'h0042_2021;
    localparam logic [31:0] BEQ    = 32'h1022_0004;
    localparam logic [31:0] ERET   = 32'h4200_0018;
    localparam logic [31:0] BADOP  = 32'hFC00_0000;
    localparam logic [31:0] BRK    = 32'h0000_000D;
    localparam logic [31:0] RIMMX  = 32'h0405_0000;

    dual_issue_decode_queue dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_cnt    (in_cnt),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .q_count   (q_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] n, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] pc0);
        in_valid = 1'b1;
        in_cnt   = n;
        in_instr = {i1, i0};
        in_pc    = {pc0 + 32'd4, pc0};
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] kins(input int k);
        return 32'h3401_0000 | 32'(k);
    endfunction

    function automatic logic [31:0] kpc(input int k);
        return 32'h0000_1000 + 32'(4 * k);
    endfunction

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_cnt = 2'd0;
        in_instr = '0; in_pc = '0; out_ready = 1'b1;
        #1;
        chk("rst_qcount", q_count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_instr", out_instr, 0);
        chk("rst_ctrl", out_ctrl, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Independent addu/ori pair issues together two edges after the push.
        push(2, ADDU, ORI, 32'hBFC0_0000);
        chk("t1_q_after_push", q_count, 2);
        chk("t1_no_bypass", out_valid, 0);
        step();
        chk("t1_valid", out_valid, 2'b11);
        chk("t1_ctrl0", out_ctrl[16:0], 17'b11000000000000000);
        chk("t1_ctrl1", out_ctrl[33:17], 17'b10100000000000000);
        chk("t1_instr", out_instr, {ORI, ADDU});
        chk("t1_pc", out_pc, {32'hBFC0_0004, 32'hBFC0_0000});
        chk("t1_q_empty", q_count, 0);
        step();
        chk("t1_drop", out_valid, 0);

        // RAW on $2 splits the pair.
        push(2, ADDIU, ADDU_R, 32'h100);
        step();
        chk("t2_valid", out_valid, 2'b01);
        chk("t2_instr0", out_instr[31:0], ADDIU);
        chk("t2_ctrl0", out_ctrl[16:0], 17'h14000);
        chk("t2_q", q_count, 1);
        step();
        chk("t2_valid_b", out_valid, 2'b01);
        chk("t2_instr0_b", out_instr[31:0], ADDU_R);
        chk("t2_pc0_b", out_pc[31:0], 32'h104);
        chk("t2_ctrl0_b", out_ctrl[16:0], 17'h18000);
        step();
        chk("t2_drop", out_valid, 0);

        // Branch in slot0 issues alone; eret decodes to eret only.
        push(2, BEQ, ADDU, 32'h200);
        step();
        chk("t3_valid", out_valid, 2'b01);
        chk("t3_ctrl_beq", out_ctrl[16:0], 17'h02000);
        step();
        chk("t3_instr_addu", out_instr[31:0], ADDU);
        chk("t3_valid_b", out_valid, 2'b01);
        step();
        push(1, ERET, 32'h0, 32'h300);
        step();
        chk("t3_eret_valid", out_valid, 2'b01);
        chk("t3_eret_ctrl", out_ctrl[16:0], 17'h00004);
        step();

        // Unknown opcode, BREAK and unknown REGIMM rt.
        push(2, ADDU, BADOP, 32'h400);
        step();
        chk("t6_reserve_unpaired", out_valid, 2'b01);
        step();
        chk("t6_reserve_ctrl", out_ctrl[16:0], 17'h00008);
        step();
        push(2, ADDU, BRK, 32'h500);
        step();
        chk("t6_brk_unpaired", out_valid, 2'b01);
        step();
        chk("t6_brk_ctrl", out_ctrl[16:0], 17'h00020);
        step();
        push(2, ADDU, RIMMX, 32'h600);
        step();
        chk("t6_regimm_pair", out_valid, 2'b11);
        chk("t6_regimm_ctrl", out_ctrl[33:17], 17'h0);
        step();

        // Fill with the output stalled, then drain and check order across the wrap.
        out_ready = 1'b0;
        push(2, kins(0), kins(1), kpc(0));
        step();
        chk("t4_first_pair", out_instr, {kins(1), kins(0)});
        push(1, kins(2), 32'h0, kpc(2));
        push(2, kins(3), kins(4), kpc(3));
        push(2, kins(5), kins(6), kpc(5));
        chk("t4_ready_at5", in_ready, 1);
        push(2, kins(7), kins(8), kpc(7));
        chk("t4_q7", q_count, 7);
        chk("t4_not_ready_1free", in_ready, 0);
        in_valid = 1'b1; in_cnt = 2'd2; in_instr = {kins(10), kins(9)}; in_pc = {kpc(10), kpc(9)};
        step();
        step();
        in_valid = 1'b0;
        chk("t4_q_hold", q_count, 7);
        chk("t4_out_hold", out_instr, {kins(1), kins(0)});
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("t4_drain_i0", out_instr[31:0], kins(2 + 2 * j));
            chk("t4_drain_pc0", out_pc[31:0], kpc(2 + 2 * j));
            if (j < 3) begin
                chk("t4_drain_pair", out_valid, 2'b11);
                chk("t4_drain_i1", out_instr[63:32], kins(3 + 2 * j));
            end else begin
                chk("t4_drain_last", out_valid, 2'b01);
            end
        end
        chk("t4_q_zero", q_count, 0);
        step();
        chk("t4_empty", out_valid, 0);

        // Flush beats a simultaneous push.
        out_ready = 1'b0;
        push(2, kins(20), kins(21), kpc(20));
        step();
        push(1, kins(22), 32'h0, kpc(22));
        push(2, kins(23), kins(24), kpc(23));
        push(2, kins(25), kins(26), kpc(25));
        chk("t5_q5", q_count, 5);
        chk("t5_valid11", out_valid, 2'b11);
        flush = 1'b1;
        in_valid = 1'b1; in_cnt = 2'd2; in_instr = {kins(31), kins(30)}; in_pc = {kpc(31), kpc(30)};
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_q_flushed", q_count, 0);
        chk("t5_valid_flushed", out_valid, 0);
        out_ready = 1'b1;
        step();
        step();
        chk("t5_push_dropped_v", out_valid, 0);
        chk("t5_push_dropped_q", q_count, 0);
        push(2, kins(40), kins(41), 32'h2000);
        step();
        chk("t5_after_flush", out_instr[31:0], kins(40));
        chk("t5_after_flush_pc", out_pc[31:0], 32'h2000);

        // Asynchronous reset mid-operation.
        push(2, kins(42), kins(43), 32'h3000);
        chk("rst2_pre_q", q_count, 2);
        #3 resetn = 1'b0;
        #1;
        chk("rst2_q", q_count, 0);
        chk("rst2_valid", out_valid, 0);
        chk("rst2_instr", out_instr, 0);
        chk("rst2_in_ready", in_ready, 1);
        @(posedge clk);
        #1 resetn = 1'b1;
        step();
        chk("rst2_stays_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
